// File: rtl/mat2_mac_datapath.sv
`default_nettype none
// ============================================================================
// Module   : mat2_mac_datapath
// Brief    : 2x2 by 2x2 unsigned matrix product datapath. It builds eight
//            element products, reduces them to four C entries, and streams C
//            out over a valid/ready handshake when the control FSM reaches
//            its Store state.
// Revision : 1.0 - initial release
// ============================================================================
module mat2_mac_datapath #(
    parameter int W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_matrix,
    input  logic [3:0]       count,
    input  logic [2:0]       entry,
    input  logic             done,
    input  logic [4*W-1:0]   a_flat,
    input  logic [4*W-1:0]   b_flat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W:0]     out_data,
    output logic [1:0]       out_index,
    output logic             out_last,
    output logic             overrun
);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    localparam logic [1:0] c_last_index = 2'd3;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [W-1:0]    w_a    [4];
    logic [W-1:0]    w_b    [4];
    logic [2*W-1:0]  w_prod [8];
    logic [2*W:0]    w_sum  [4];

    logic [2*W-1:0]  r_p    [8];
    logic [2*W:0]    r_c    [4];
    logic [2*W:0]    r_buf  [4];

    logic            r_armed;
    logic            r_done_d;
    logic [1:0]      r_index;
    logic            r_overrun;

    logic            w_done_rise;
    logic            w_load_buf;
    logic            w_advance;
    logic            w_finish;
    logic            w_acc_en;

    // Unpack the flat operand buses into element arrays
    generate
        for (genvar n = 0; n < 4; n++) begin : g_unpack
            assign w_a[n] = a_flat[n*W +: W];
            assign w_b[n] = b_flat[n*W +: W];
        end
    endgenerate

    // One multiplier per product slot; count = {i, j, k}
    generate
        for (genvar n = 0; n < 8; n++) begin : g_prod
            localparam int I = n / 4;
            localparam int J = (n / 2) % 2;
            localparam int K = n % 2;
            assign w_prod[n] = {{W{1'b0}}, w_a[2*I+K]} * {{W{1'b0}}, w_b[2*K+J]};
        end
    endgenerate

    // Pairwise sums, one bit wider than a product so nothing wraps
    generate
        for (genvar e = 0; e < 4; e++) begin : g_sum
            assign w_sum[e] = {1'b0, r_p[2*e]} + {1'b0, r_p[2*e+1]};
        end
    endgenerate

    assign w_done_rise = done && !r_done_d;
    assign w_acc_en    = r_armed && !load_matrix && !done && !entry[2];

    // Product file: capture the product selected by count during the multiply phase
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int n = 0; n < 8; n++) begin
                r_p[n] <= '0;
            end
        end else if (load_matrix && !count[3]) begin
            r_p[count[2:0]] <= w_prod[count[2:0]];
        end
    end

    // armed marks that products exist which have not yet been handed to a stream
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_armed <= 1'b0;
        end else if (w_done_rise) begin
            r_armed <= 1'b0;
        end else if (load_matrix) begin
            r_armed <= 1'b1;
        end
    end

    // Previous done, for rising-edge detection
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_done_d <= 1'b0;
        end else begin
            r_done_d <= done;
        end
    end

    // Accumulate: only while armed, so an idle entry=0 never clobbers C[0]
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int e = 0; e < 4; e++) begin
                r_c[e] <= '0;
            end
        end else if (w_acc_en) begin
            r_c[entry[1:0]] <= w_sum[entry[1:0]];
        end
    end

    // Output FSM state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Output FSM next-state and handshake decode
    always_comb begin
        w_state_nxt = r_state;
        w_load_buf  = 1'b0;
        w_advance   = 1'b0;
        w_finish    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_done_rise) begin
                    w_load_buf  = 1'b1;
                    w_state_nxt = S_STREAM;
                end
            end
            S_STREAM: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (r_index == c_last_index) begin
                        w_finish    = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_advance = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Output buffer and beat index; a rise while streaming leaves them alone
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int e = 0; e < 4; e++) begin
                r_buf[e] <= '0;
            end
            r_index <= 2'd0;
        end else if (w_load_buf) begin
            for (int e = 0; e < 4; e++) begin
                r_buf[e] <= r_c[e];
            end
            r_index <= 2'd0;
        end else if (w_advance) begin
            r_index <= r_index + 2'd1;
        end else if (w_finish) begin
            r_index <= 2'd0;
        end
    end

    // Sticky overrun: a result set arrived while the previous one was draining
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_overrun <= 1'b0;
        end else if (w_done_rise && (r_state == S_STREAM)) begin
            r_overrun <= 1'b1;
        end
    end

    assign out_data  = out_valid ? r_buf[r_index] : '0;
    assign out_index = out_valid ? r_index : 2'd0;
    assign out_last  = out_valid && (r_index == c_last_index);
    assign overrun   = r_overrun;

endmodule
`default_nettype wire
